// File: rtl/fetch_bundle_queue.sv
// ---------------------------------------------------------------------------
// FetchBundleQueue (module fetch_bundle_queue)
//
// Purpose:
//   Fetch front-end that sits between a wide instruction memory and the issue
//   controller. It prefetches FETCH_WIDTH-word bundles into a DEPTH-entry
//   queue and presents the head bundle to the issuer, which may consume any
//   number of words per cycle. A redirect flushes the queue and the fetch in
//   flight, then restarts fetching from the redirect PC.
//
// Optional feature macro:
//   FETCH_PERF_COUNTERS_EN - when defined, o_perf_stall counts the cycles in
//   which fetch was held off by a full queue and o_perf_flush counts accepted
//   redirects. When undefined both outputs are tied to zero.
//
// Parameters:
//   FETCH_WIDTH      words per bundle (>= 1)
//   DEPTH            bundle slots in the queue (power of two, >= 2)
//   START_BYTE_ADDR  first PC fetched after reset
//
// Ports:
//   clk                clock
//   rst_n              asynchronous active-low reset
//   o_imem_addr        byte address to instruction memory (combinational)
//   i_imem_data        packed bundle, valid one cycle after o_imem_addr
//   i_redirect_valid   flush and refetch from i_redirect_pc
//   i_redirect_pc      new PC, word aligned
//   o_out_valid        head bundle has at least one unconsumed word
//   o_out_pc           byte PC of o_out_bundle word 0
//   o_out_bundle       head words starting at the consume offset, tail zeroed
//   o_out_num          unconsumed words in the head bundle
//   i_deq_count        words consumed this cycle (0..o_out_num)
//   o_perf_stall       cycles fetch was blocked by a full queue
//   o_perf_flush       redirects accepted
// ---------------------------------------------------------------------------
module fetch_bundle_queue #(
    parameter int          FETCH_WIDTH     = 8,
    parameter int          DEPTH           = 4,
    parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000,
    localparam int         NUM_W           = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [31:0]              o_imem_addr,
    input  logic [FETCH_WIDTH*32-1:0] i_imem_data,
    input  logic                     i_redirect_valid,
    input  logic [31:0]              i_redirect_pc,
    output logic                     o_out_valid,
    output logic [31:0]              o_out_pc,
    output logic [FETCH_WIDTH*32-1:0] o_out_bundle,
    output logic [NUM_W-1:0]         o_out_num,
    input  logic [NUM_W-1:0]         i_deq_count,
    output logic [31:0]              o_perf_stall,
    output logic [31:0]              o_perf_flush
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Queue storage: one packed bundle plus its byte PC per slot.
    logic [FETCH_WIDTH*32-1:0] r_qData [DEPTH];
    logic [31:0]               r_qPc   [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [NUM_W-1:0] r_offset;
    logic [31:0]      r_fetchPc;
    logic             r_inflight;
    logic [31:0]      r_inflightPc;

    logic                      w_fire;
    logic                      w_capture;
    logic                      w_pop;
    logic [NUM_W-1:0]          w_deqEff;
    logic [NUM_W-1:0]          w_offsetSum;
    logic [FETCH_WIDTH*32-1:0] w_headData;
    logic [31:0]               w_headPc;

    // A redirect always wins the memory port. Otherwise fetch only when a
    // slot is guaranteed for the returning bundle; a pop in the same cycle
    // earns no credit, which keeps the capture path free of any space check.
    always_comb begin
        o_imem_addr = i_redirect_valid ? i_redirect_pc : r_fetchPc;
        w_fire      = i_redirect_valid |
                      ((32'(r_count) + 32'(r_inflight)) < 32'(DEPTH));
        w_capture   = r_inflight & ~i_redirect_valid;
    end

    // Head view and dequeue arithmetic. An over-sized or spurious dequeue is
    // clamped to what the head actually holds so the queue never underflows.
    always_comb begin
        w_headData  = r_qData[r_head];
        w_headPc    = r_qPc[r_head];
        o_out_valid = (r_count != '0);
        o_out_num   = '0;
        o_out_pc    = '0;
        if (o_out_valid) begin
            o_out_num = NUM_W'(FETCH_WIDTH) - r_offset;
            o_out_pc  = w_headPc + (32'(r_offset) << 2);
        end
        w_deqEff = '0;
        if (o_out_valid) begin
            w_deqEff = (i_deq_count > o_out_num) ? o_out_num : i_deq_count;
        end
        w_offsetSum = r_offset + w_deqEff;
        w_pop       = o_out_valid & (w_offsetSum == NUM_W'(FETCH_WIDTH));
    end

    // Shift the head bundle down by the consume offset; slots past the end
    // of the bundle read as zero.
    always_comb begin
        o_out_bundle = '0;
        if (o_out_valid) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if ((k + int'(r_offset)) < FETCH_WIDTH) begin
                    o_out_bundle[k*32 +: 32] =
                        w_headData[(k + int'(r_offset))*32 +: 32];
                end
            end
        end
    end

    // Control state. The fetch in flight is tracked by a single flag because
    // memory answers in exactly one cycle. A redirect clears the queue and
    // drops the returning bundle by suppressing its capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_offset     <= '0;
            r_fetchPc    <= START_BYTE_ADDR;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
        end else begin
            r_inflight <= w_fire;
            if (w_fire) begin
                r_inflightPc <= o_imem_addr;
                r_fetchPc    <= o_imem_addr + 32'(4 * FETCH_WIDTH);
            end
            if (i_redirect_valid) begin
                r_head   <= '0;
                r_tail   <= '0;
                r_count  <= '0;
                r_offset <= '0;
            end else begin
                if (w_capture) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head   <= r_head + PTR_W'(1);
                    r_offset <= '0;
                end else begin
                    r_offset <= w_offsetSum;
                end
                r_count <= r_count + CNT_W'(w_capture) - CNT_W'(w_pop);
            end
        end
    end

    // Bundle storage needs no reset: a slot is only read after it has been
    // written, since the head view is gated by a non-zero count.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_qData[r_tail] <= i_imem_data;
            r_qPc[r_tail]   <= r_inflightPc;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_perfStall;
    logic [31:0] r_perfFlush;

    // Without a redirect the only reason not to fire is a full queue, so
    // !w_fire is exactly the stall condition. Both counters wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perfStall <= '0;
            r_perfFlush <= '0;
        end else begin
            if (!w_fire) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
            if (i_redirect_valid) begin
                r_perfFlush <= r_perfFlush + 32'd1;
            end
        end
    end

    assign o_perf_stall = r_perfStall;
    assign o_perf_flush = r_perfFlush;
`else
    assign o_perf_stall = 32'h0;
    assign o_perf_flush = 32'h0;
`endif

    // The issuer may never take more words than the head offers; a redirect
    // cycle ignores the dequeue request entirely.
    a_deqLegal: assert property (@(posedge clk) disable iff (!rst_n)
        i_redirect_valid || (i_deq_count <= o_out_num));

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// ---------------------------------------------------------------------------
// Testbench for fetch_bundle_queue (default build, perf counters disabled).
// The memory model answers one cycle after the address with word j of a
// bundle equal to (address + 4*j) ^ KEY, so every expected word is derived
// from its byte PC.
// ---------------------------------------------------------------------------
module tb_fetch_bundle_queue;

    localparam int          FW  = 8;
    localparam int          NW  = $clog2(FW + 1);
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic              clk;
    logic              rstN;
    logic [31:0]       imemAddr;
    logic [FW*32-1:0]  imemData;
    logic              redirectValid;
    logic [31:0]       redirectPc;
    logic              outValid;
    logic [31:0]       outPc;
    logic [FW*32-1:0]  outBundle;
    logic [NW-1:0]     outNum;
    logic [NW-1:0]     deqCount;
    logic [31:0]       perfStall;
    logic [31:0]       perfFlush;

    int nChecks;
    int nPassed;

    fetch_bundle_queue #(
        .FETCH_WIDTH     (FW),
        .DEPTH           (4),
        .START_BYTE_ADDR (32'h0000_3000)
    ) dut (
        .clk              (clk),
        .rst_n            (rstN),
        .o_imem_addr      (imemAddr),
        .i_imem_data      (imemData),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .o_out_valid      (outValid),
        .o_out_pc         (outPc),
        .o_out_bundle     (outBundle),
        .o_out_num        (outNum),
        .i_deq_count      (deqCount),
        .o_perf_stall     (perfStall),
        .o_perf_flush     (perfFlush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency instruction memory.
    always @(posedge clk) begin
        for (int j = 0; j < FW; j++) begin
            imemData[j*32 +: 32] <= (imemAddr + 32'(4 * j)) ^ KEY;
        end
    end

    function automatic logic [31:0] outWord(input int k);
        return outBundle[k*32 +: 32];
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ KEY;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive this cycle's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic [NW-1:0] deq);
        redirectValid = rv;
        redirectPc    = rpc;
        deqCount      = deq;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nChecks       = 0;
        nPassed       = 0;
        rstN          = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        deqCount      = '0;

        // Reset state
        repeat (2) nextCycle();
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_num", 32'(outNum), 32'd0);
        checkOutput("rst_word0", outWord(0), 32'd0);
        checkOutput("rst_addr", imemAddr, 32'h0000_3000);
        checkOutput("rst_stall", perfStall, 32'd0);

        // Startup latency: release in cycle 0, first bundle in cycle 2
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("c1_valid", 32'(outValid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("c2_valid", 32'(outValid), 32'd1);
        checkOutput("c2_pc", outPc, 32'h0000_3000);
        checkOutput("c2_num", 32'(outNum), 32'd8);
        checkOutput("c2_word0", outWord(0), memWord(32'h3000));
        checkOutput("c2_word7", outWord(7), memWord(32'h301C));

        // Fill to capacity: four bundles fetched, address parks at 0x3080
        repeat (4) nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd3);
        checkOutput("full_addr", imemAddr, 32'h0000_3080);
        checkOutput("full_pc", outPc, 32'h0000_3000);
        checkOutput("full_stall_off", perfStall, 32'd0);

        // Partial consume of 3, then 5 to pop the head
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd5);
        checkOutput("part_pc", outPc, 32'h0000_300C);
        checkOutput("part_num", 32'(outNum), 32'd5);
        checkOutput("part_word0", outWord(0), memWord(32'h300C));
        checkOutput("part_word4", outWord(4), memWord(32'h301C));
        checkOutput("part_word5", outWord(5), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("pop_pc", outPc, 32'h0000_3020);
        checkOutput("pop_num", 32'(outNum), 32'd8);
        checkOutput("pop_word0", outWord(0), memWord(32'h3020));

        // Refill, then redirect while full with a full dequeue request
        repeat (2) nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd8);
        checkOutput("refull_addr", imemAddr, 32'h0000_30A0);
        applyStimulus(1'b1, 32'h0000_3104, 4'd8);
        checkOutput("redir_addr", imemAddr, 32'h0000_3104);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("redir_t1_valid", 32'(outValid), 32'd0);
        checkOutput("redir_t1_word0", outWord(0), 32'd0);
        checkOutput("redir_t1_addr", imemAddr, 32'h0000_3124);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("redir_t2_valid", 32'(outValid), 32'd1);
        checkOutput("redir_t2_pc", outPc, 32'h0000_3104);
        checkOutput("redir_t2_word0", outWord(0), memWord(32'h3104));
        checkOutput("redir_flush_off", perfFlush, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("redir_t3_pc", outPc, 32'h0000_3104);

        // Back-to-back redirects: only the second stream appears, at T+3
        nextCycle();
        applyStimulus(1'b1, 32'h0000_3200, 4'd0);
        checkOutput("b2b_addr0", imemAddr, 32'h0000_3200);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_3300, 4'd0);
        checkOutput("b2b_t1_valid", 32'(outValid), 32'd0);
        checkOutput("b2b_addr1", imemAddr, 32'h0000_3300);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("b2b_t2_valid", 32'(outValid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd8);
        checkOutput("b2b_t3_valid", 32'(outValid), 32'd1);
        checkOutput("b2b_t3_pc", outPc, 32'h0000_3300);
        checkOutput("b2b_t3_word0", outWord(0), memWord(32'h3300));
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("b2b_t4_pc", outPc, 32'h0000_3320);

        // Address wrap past 0xFFFF_FFFF
        applyStimulus(1'b1, 32'hFFFF_FFF0, 4'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("wrap_addr", imemAddr, 32'h0000_0010);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd4);
        checkOutput("wrap_pc", outPc, 32'hFFFF_FFF0);
        checkOutput("wrap_word3", outWord(3), memWord(32'hFFFF_FFFC));
        checkOutput("wrap_word4", outWord(4), memWord(32'h0000_0000));
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("wrap_off_pc", outPc, 32'h0000_0000);
        checkOutput("wrap_off_num", 32'(outNum), 32'd4);
        checkOutput("wrap_off_word0", outWord(0), memWord(32'h0000_0000));
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd4);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("wrap_next_pc", outPc, 32'h0000_0010);

        // Mid-stream reset for one cycle
        rstN = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(outValid), 32'd0);
        checkOutput("mrst_num", 32'(outNum), 32'd0);
        checkOutput("mrst_word0", outWord(0), 32'd0);
        checkOutput("mrst_addr", imemAddr, 32'h0000_3000);
        nextCycle();
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("mrst_c1_valid", 32'(outValid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 4'd0);
        checkOutput("mrst_c2_pc", outPc, 32'h0000_3000);
        checkOutput("mrst_c2_num", 32'(outNum), 32'd8);
        checkOutput("end_stall", perfStall, 32'd0);
        checkOutput("end_flush", perfFlush, 32'd0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
